// File: rtl/sram_like_arbiter_nx1.sv
// N-to-1 sram-like arbiter: fixed-priority or round-robin grant with stall locking,
// plus an in-flight ID FIFO that steers each downstream data_ok back to its issuer.
module sram_like_arbiter_nx1 #(
    parameter int N_MASTERS       = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ARB_MODE        = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_MASTERS-1:0]    m_req,
    input  logic [N_MASTERS-1:0]    m_wr,
    input  logic [2*N_MASTERS-1:0]  m_size,
    input  logic [32*N_MASTERS-1:0] m_addr,
    input  logic [32*N_MASTERS-1:0] m_wdata,
    output logic [N_MASTERS-1:0]    m_addr_ok,
    output logic [N_MASTERS-1:0]    m_data_ok,
    output logic [32*N_MASTERS-1:0] m_rdata,
    output logic                    s_req,
    output logic                    s_wr,
    output logic [1:0]              s_size,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    input  logic [31:0]             s_rdata,
    input  logic                    s_addr_ok,
    input  logic                    s_data_ok
);
    localparam int IDW = $clog2(N_MASTERS);
    localparam int PW  = $clog2(MAX_OUTSTANDING);
    localparam int CW  = PW + 1;

    logic [IDW-1:0] fifo_id [MAX_OUTSTANDING];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           lock_vld;
    logic [IDW-1:0] lock_id;
    logic [IDW-1:0] rr_ptr;

    logic           locked;
    logic           fifo_full;
    logic           issue;
    logic           accept;
    logic           pop;
    logic [IDW-1:0] arb_id;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] head_id;

    function automatic logic [IDW-1:0] pick(input logic [N_MASTERS-1:0] req,
                                            input logic [IDW-1:0]       start);
        logic [IDW-1:0] id;
        logic           found;
        int             idx;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_MASTERS; k++) begin
            idx = (ARB_MODE == 1) ? (int'(start) + k) % N_MASTERS : k;
            if (!found && req[idx]) begin
                id    = IDW'(idx);
                found = 1'b1;
            end
        end
        return id;
    endfunction

    // A lock only holds while its owner keeps requesting, so a dropped request cannot
    // leave the slave port pointed at an idle master.
    assign locked    = lock_vld && m_req[lock_id];
    assign arb_id    = pick(m_req, rr_ptr);
    assign grant     = locked ? lock_id : arb_id;
    assign fifo_full = (count == CW'(MAX_OUTSTANDING));
    assign issue     = !rst && (|m_req) && !fifo_full;
    assign accept    = issue && s_addr_ok;
    assign head_id   = fifo_id[rd_ptr];
    assign pop       = !rst && s_data_ok && (count != '0);

    assign s_req     = issue;
    assign s_wr      = issue && m_wr[grant];
    assign s_size    = issue ? m_size[int'(grant)*2 +: 2] : 2'b00;
    assign s_addr    = issue ? m_addr[int'(grant)*32 +: 32] : 32'h0;
    assign s_wdata   = issue ? m_wdata[int'(grant)*32 +: 32] : 32'h0;
    assign m_addr_ok = accept ? (N_MASTERS'(1) << grant) : '0;
    assign m_data_ok = pop ? (N_MASTERS'(1) << head_id) : '0;
    assign m_rdata   = {N_MASTERS{s_rdata}};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            lock_vld <= 1'b0;
            lock_id  <= '0;
            rr_ptr   <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(accept) - CW'(pop);
            if (issue && !s_addr_ok) begin
                lock_vld <= 1'b1;
                lock_id  <= grant;
            end else if (s_addr_ok || !locked) begin
                lock_vld <= 1'b0;
            end
            if (ARB_MODE == 1 && accept) begin
                rr_ptr <= (int'(grant) == N_MASTERS - 1) ? '0 : grant + IDW'(1);
            end
        end
    end

    // ID storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_id[wr_ptr] <= grant;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter_nx1.sv
// Bench for sram_like_arbiter_nx1: a fixed-priority and a round-robin instance share stimulus;
// directed vectors, hand-written corner sequences, then randomized runs against a queue model.
module tb_sram_like_arbiter_nx1;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  m_req, m_wr;
    logic [5:0]  m_size;
    logic [95:0] m_addr, m_wdata;
    logic [31:0] s_rdata;
    logic        s_addr_ok, s_data_ok;

    logic [2:0]  m_addr_ok_f, m_data_ok_f, m_addr_ok_r, m_data_ok_r;
    logic [95:0] m_rdata_f, m_rdata_r;
    logic        s_req_f, s_wr_f, s_req_r, s_wr_r;
    logic [1:0]  s_size_f, s_size_r;
    logic [31:0] s_addr_f, s_wdata_f, s_addr_r, s_wdata_r;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ma [3];
    logic        mw [3];
    logic [1:0]  ms [3];
    logic [31:0] md [3];

    always #5 clk = ~clk;

    sram_like_arbiter_nx1 #(.N_MASTERS(3), .MAX_OUTSTANDING(4), .ARB_MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok_f),
        .m_data_ok(m_data_ok_f), .m_rdata(m_rdata_f), .s_req(s_req_f), .s_wr(s_wr_f),
        .s_size(s_size_f), .s_addr(s_addr_f), .s_wdata(s_wdata_f), .s_rdata(s_rdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok));

    sram_like_arbiter_nx1 #(.N_MASTERS(3), .MAX_OUTSTANDING(4), .ARB_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok_r),
        .m_data_ok(m_data_ok_r), .m_rdata(m_rdata_r), .s_req(s_req_r), .s_wr(s_wr_r),
        .s_size(s_size_r), .s_addr(s_addr_r), .s_wdata(s_wdata_r), .s_rdata(s_rdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok));

    typedef struct {
        logic       r;
        logic [2:0] req;
        logic       aok;
        logic       dok;
        int         g0;
        int         g1;
        logic [2:0] d0;
        logic [2:0] d1;
    } vec_t;

    function automatic vec_t mk(logic r, logic [2:0] req, logic aok, logic dok,
                                int g0, int g1, logic [2:0] d0, logic [2:0] d1);
        vec_t v;
        v.r = r; v.req = req; v.aok = aok; v.dok = dok;
        v.g0 = g0; v.g1 = g1; v.d0 = d0; v.d1 = d1;
        return v;
    endfunction

    task automatic chk(input string tag, input string nm, input int which,
                       input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s %s dut%0d: got %0h expected %0h", tag, nm, which, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge and let them settle.
    task automatic step(input logic r, input logic [2:0] req, input logic aok, input logic dok);
        @(negedge clk);
        rst       = r;
        m_req     = req;
        for (int i = 0; i < 3; i++) begin
            m_wr[i]            = mw[i];
            m_size[i*2 +: 2]   = ms[i];
            m_addr[i*32 +: 32] = ma[i];
            m_wdata[i*32 +: 32] = md[i];
        end
        s_addr_ok = aok;
        s_data_ok = dok;
        s_rdata   = $urandom;
        #1;
    endtask

    // g < 0 means no request must be forwarded.
    task automatic check_dut(input int which, input int g, input logic aok,
                             input logic [2:0] d, input string tag);
        logic        sr, sw;
        logic [1:0]  ssz;
        logic [31:0] sa, swd;
        logic [2:0]  ao, dk;
        logic [95:0] rd;
        logic        e_wr;
        logic [1:0]  e_sz;
        logic [31:0] e_a, e_wd;
        logic [2:0]  e_ao;
        if (which == 0) begin
            sr = s_req_f; sw = s_wr_f; ssz = s_size_f; sa = s_addr_f; swd = s_wdata_f;
            ao = m_addr_ok_f; dk = m_data_ok_f; rd = m_rdata_f;
        end else begin
            sr = s_req_r; sw = s_wr_r; ssz = s_size_r; sa = s_addr_r; swd = s_wdata_r;
            ao = m_addr_ok_r; dk = m_data_ok_r; rd = m_rdata_r;
        end
        e_wr = 1'b0; e_sz = 2'b00; e_a = 32'h0; e_wd = 32'h0; e_ao = 3'b000;
        if (g >= 0) begin
            e_wr = mw[g]; e_sz = ms[g]; e_a = ma[g]; e_wd = md[g];
            if (aok) e_ao = 3'(1 << g);
        end
        chk(tag, "s_req", which, 64'(sr), 64'(g >= 0));
        chk(tag, "s_addr", which, 64'(sa), 64'(e_a));
        chk(tag, "s_wr", which, 64'(sw), 64'(e_wr));
        chk(tag, "s_size", which, 64'(ssz), 64'(e_sz));
        chk(tag, "s_wdata", which, 64'(swd), 64'(e_wd));
        chk(tag, "m_addr_ok", which, 64'(ao), 64'(e_ao));
        chk(tag, "m_data_ok", which, 64'(dk), 64'(d));
        for (int i = 0; i < 3; i++) begin
            if (d[i]) chk(tag, "m_rdata", which, 64'(rd[i*32 +: 32]), 64'(s_rdata));
        end
    endtask

    task automatic cyc(input vec_t v, input string tag);
        step(v.r, v.req, v.aok, v.dok);
        check_dut(0, v.g0, v.aok, v.d0, tag);
        check_dut(1, v.g1, v.aok, v.d1, tag);
    endtask

    // Reference: queue of issuing masters in acceptance order, stall owner, next RR start.
    task automatic run_random(input int mode, input int cycles);
        int         q[$];
        int         lock, rr, eg, idx;
        logic [2:0] pend, ed;
        logic       r, aok, dok;
        lock = -1; rr = 0; pend = 3'b000; idx = 0;
        step(1'b1, 3'b000, 1'b0, 1'b0);
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1'b1;
                    ma[i] = $urandom; mw[i] = 1'($urandom_range(1));
                    ms[i] = 2'($urandom_range(2)); md[i] = $urandom;
                end
            end
            r   = ($urandom_range(99) == 0);
            aok = ($urandom_range(2) != 0);
            dok = ($urandom_range(2) == 0);
            step(r, pend, aok, dok);
            eg = -1; ed = 3'b000;
            if (!r) begin
                if (pend != 3'b000 && q.size() < 4) begin
                    if (lock >= 0 && pend[lock]) eg = lock;
                    else begin
                        for (int k = 0; k < 3; k++) begin
                            idx = (mode == 1) ? (rr + k) % 3 : k;
                            if (eg < 0 && pend[idx]) eg = idx;
                        end
                    end
                end
                if (dok && q.size() > 0) ed = 3'(1 << q[0]);
            end
            check_dut(mode, eg, aok, ed, mode == 1 ? "rand_rr" : "rand_fp");
            if (r) begin
                q.delete(); lock = -1; rr = 0;
            end else begin
                if (ed != 3'b000) void'(q.pop_front());
                if (eg >= 0 && aok) begin
                    q.push_back(eg);
                    pend[eg] = 1'b0;
                    if (mode == 1) rr = (eg + 1) % 3;
                end
                if (eg >= 0 && !aok) lock = eg;
                else if (aok) lock = -1;
                else if (lock >= 0 && !pend[lock]) lock = -1;
            end
        end
    endtask

    initial begin
        vec_t tab[$];
        rst = 1'b1; m_req = '0; m_wr = '0; m_size = '0; m_addr = '0; m_wdata = '0;
        s_rdata = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
        ma[0] = 32'h0000_1000; ma[1] = 32'h1FC0_0000; ma[2] = 32'h2000_0200;
        mw[0] = 1'b0; mw[1] = 1'b0; mw[2] = 1'b1;
        ms[0] = 2'd2; ms[1] = 2'd2; ms[2] = 2'd1;
        md[0] = 32'h1111_1111; md[1] = 32'h2222_2222; md[2] = 32'h3333_3333;

        //           r     req     aok   dok   g0  g1  d0      d1
        tab.push_back(mk(1'b1, 3'b000, 1'b0, 1'b0, -1, -1, 3'b000, 3'b000));
        tab.push_back(mk(1'b0, 3'b010, 1'b1, 1'b0,  1,  1, 3'b000, 3'b000));
        tab.push_back(mk(1'b0, 3'b000, 1'b0, 1'b0, -1, -1, 3'b000, 3'b000));
        tab.push_back(mk(1'b0, 3'b000, 1'b0, 1'b1, -1, -1, 3'b010, 3'b010));
        tab.push_back(mk(1'b0, 3'b000, 1'b0, 1'b1, -1, -1, 3'b000, 3'b000));
        tab.push_back(mk(1'b1, 3'b111, 1'b1, 1'b1, -1, -1, 3'b000, 3'b000));
        tab.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0,  0,  0, 3'b000, 3'b000));
        tab.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0,  0,  1, 3'b000, 3'b000));
        tab.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0,  0,  2, 3'b000, 3'b000));
        tab.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0,  0,  0, 3'b000, 3'b000));
        tab.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0, -1, -1, 3'b000, 3'b000));
        tab.push_back(mk(1'b0, 3'b111, 1'b1, 1'b1, -1, -1, 3'b001, 3'b001));
        tab.push_back(mk(1'b0, 3'b111, 1'b1, 1'b0,  0,  1, 3'b000, 3'b000));
        tab.push_back(mk(1'b0, 3'b111, 1'b1, 1'b1, -1, -1, 3'b001, 3'b010));
        tab.push_back(mk(1'b0, 3'b000, 1'b0, 1'b1, -1, -1, 3'b001, 3'b100));
        tab.push_back(mk(1'b0, 3'b100, 1'b1, 1'b1,  2,  2, 3'b001, 3'b001));
        tab.push_back(mk(1'b0, 3'b000, 1'b0, 1'b1, -1, -1, 3'b001, 3'b010));
        tab.push_back(mk(1'b0, 3'b000, 1'b0, 1'b1, -1, -1, 3'b100, 3'b100));
        tab.push_back(mk(1'b0, 3'b000, 1'b0, 1'b1, -1, -1, 3'b000, 3'b000));
        foreach (tab[i]) cyc(tab[i], $sformatf("vec%0d", i));

        // Stalled master 2 keeps the port while master 0 arrives mid-stall.
        cyc(mk(1'b1, 3'b000, 1'b0, 1'b0, -1, -1, 3'b000, 3'b000), "lock_rst");
        cyc(mk(1'b0, 3'b100, 1'b0, 1'b0,  2,  2, 3'b000, 3'b000), "lock_s0");
        cyc(mk(1'b0, 3'b101, 1'b0, 1'b0,  2,  2, 3'b000, 3'b000), "lock_s1");
        cyc(mk(1'b0, 3'b101, 1'b0, 1'b0,  2,  2, 3'b000, 3'b000), "lock_s2");
        cyc(mk(1'b0, 3'b101, 1'b1, 1'b0,  2,  2, 3'b000, 3'b000), "lock_acc");
        cyc(mk(1'b0, 3'b001, 1'b1, 1'b0,  0,  0, 3'b000, 3'b000), "lock_next");

        // Reset with three IDs in flight drops them all.
        cyc(mk(1'b1, 3'b000, 1'b0, 1'b0, -1, -1, 3'b000, 3'b000), "mrst_a");
        cyc(mk(1'b0, 3'b111, 1'b1, 1'b0,  0,  0, 3'b000, 3'b000), "mrst_b");
        cyc(mk(1'b0, 3'b111, 1'b1, 1'b0,  0,  1, 3'b000, 3'b000), "mrst_c");
        cyc(mk(1'b0, 3'b111, 1'b1, 1'b0,  0,  2, 3'b000, 3'b000), "mrst_d");
        cyc(mk(1'b1, 3'b111, 1'b1, 1'b1, -1, -1, 3'b000, 3'b000), "mrst_in");
        cyc(mk(1'b0, 3'b000, 1'b0, 1'b1, -1, -1, 3'b000, 3'b000), "mrst_stale");
        cyc(mk(1'b0, 3'b010, 1'b1, 1'b0,  1,  1, 3'b000, 3'b000), "mrst_new");
        cyc(mk(1'b0, 3'b000, 1'b0, 1'b1, -1, -1, 3'b010, 3'b010), "mrst_resp");

        run_random(0, 600);
        run_random(1, 600);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sram_like_arbiter_nx1.md
# sram_like_arbiter_nx1

Parametrised N-to-1 sram-like arbiter with in-order response routing, merging several sram-like masters (i cache refill, d cache refill/write-through, uncached data path) onto the single sram-like slave port of the AXI interface. It generalises the fixed two-way cached/uncached data merge:
- any number of masters;
- selectable fixed-priority or round-robin arbitration;
- grant locking while a request is stalled;
- an outstanding-transaction ID FIFO that routes each data_ok back to the master that issued the request.

## Interface
Parameters:
- N_MASTERS, 3, number of upstream sram-like masters (2..8)
- MAX_OUTSTANDING, 4, depth of the in-flight ID FIFO (power of two, 2..16)
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports (flat buses, master i occupies slice [i*W +: W]):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- m_req  in  N_MASTERS  per-master request
- m_wr  in  N_MASTERS  per-master write flag
- m_size  in  2*N_MASTERS  per-master size (0 = byte, 1 = half, 2 = word)
- m_addr  in  32*N_MASTERS  per-master physical address
- m_wdata  in  32*N_MASTERS  per-master write data
- m_addr_ok  out  N_MASTERS  one-hot request accept
- m_data_ok  out  N_MASTERS  one-hot response strobe
- m_rdata  out  32*N_MASTERS  s_rdata broadcast to every slice
- s_req, s_wr  out  1  downstream request / write flag
- s_size  out  2  downstream size
- s_addr, s_wdata  out  32  downstream address / write data
- s_rdata  in  32  downstream read data
- s_addr_ok, s_data_ok  in  1  downstream handshakes

## Operation
- Issue condition: some m_req bit set, FIFO count < MAX_OUTSTANDING, and not in reset. A full FIFO blocks issue even if a pop occurs in the same cycle.
- Grant selection:
  - When locked, grant = lock_id.
  - Otherwise, ARB_MODE 0 picks the lowest set index.
  - Otherwise, ARB_MODE 1 picks the first set index starting at rr_ptr, wrapping modulo N_MASTERS.
- Forwarding: s_req = issue. s_wr, s_size, s_addr and s_wdata come from the granted slice. When s_req = 0 they are all 0.
- Request accept: m_addr_ok[grant] = s_req & s_addr_ok. All other bits are 0.
- Grant lock:
  - Set when s_req & !s_addr_ok, capturing lock_id = grant.
  - Cleared on s_addr_ok.
  - Also cleared if m_req[lock_id] drops (protocol violation recovery).
- Round-robin pointer: on accept, rr_ptr <= (grant+1) mod N_MASTERS. It is only updated in ARB_MODE 1.
- ID FIFO:
  - Push grant on s_req & s_addr_ok.
  - Pop on s_data_ok & count != 0.
  - Push and pop in the same cycle are both performed, so count is unchanged.
  - Pointers wrap modulo MAX_OUTSTANDING. count is $clog2(MAX_OUTSTANDING)+1 bits.
- Response routing:
  - m_data_ok[head_id] = s_data_ok & count != 0.
  - s_data_ok with an empty FIFO is ignored: no pop, no m_data_ok.
- Ordering: responses return to masters strictly in acceptance order. The downstream slave is in-order.

## Timing
- Zero-cycle combinational paths: request forwarding, addr_ok return and data_ok routing.
- A request accepted in cycle T may receive data_ok no earlier than T+1. The FIFO head is registered, so a same-cycle push is not visible to the pop.
- Reset (rst = 1 at a clock edge): count, FIFO pointers, lock and rr_ptr all go to 0.
- While rst is high, s_req, m_addr_ok and m_data_ok are forced to 0.
- Reset mid-transaction discards all in-flight IDs. A late s_data_ok after reset is dropped.
- Stalled request: the downstream sees identical s_addr/s_wr/s_size/s_wdata every cycle until s_addr_ok, even if a higher-priority master raises m_req meanwhile.

## Test plan
- Single master read: N = 3, master 1 sends addr 0x1FC0_0000. Slave gives addr_ok in the same cycle and data_ok 2 cycles later with 0xDEAD_BEEF. Required: m_addr_ok = 3'b010 in the request cycle, m_data_ok = 3'b010 2 cycles later, slice 1 of m_rdata = 0xDEAD_BEEF.
- Fixed vs round-robin: all three masters hold req, slave accepts every cycle.
  - ARB_MODE 0: accepts go 0,0,0 while master 0 holds req.
  - ARB_MODE 1: accept order 0,1,2,0.
- Lock under stall:
  - Master 2 requests; slave withholds addr_ok for 3 cycles.
  - Master 0 raises req in stall cycle 1.
  - Required: s_addr stays at master 2's address every cycle until accept; master 0 is granted in the next cycle.
- FIFO full: MAX_OUTSTANDING = 4, four accepts with no data_ok.
  - Fifth request: s_req = 0, no m_addr_ok.
  - First data_ok: goes to the first accepted master.
  - The fifth request is accepted the cycle after that pop.
- Simultaneous push/pop and spurious response:
  - Accept and data_ok in the same cycle with count = 2: count stays 2, routing is correct.
  - s_data_ok with count = 0: m_data_ok = 0.
- Reset mid-operation:
  - Assert rst with 3 requests in flight; all outputs are 0 during rst.
  - After release, count = 0, and a stale s_data_ok produces no m_data_ok.
